// File: rtl/hls_mac_pipe.sv
// Pipelined multiply-accumulate lane: operand/product pipeline, grouped accumulator
// with sticky overflow, and a rounding, saturating output register.
module hls_mac_pipe #(
    parameter int unsigned A_WIDTH   = 14,
    parameter int unsigned B_WIDTH   = 13,
    parameter bit          A_SIGNED  = 1'b1,
    parameter bit          B_SIGNED  = 1'b0,
    parameter int unsigned NUM_STAGE = 3,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned OUT_SHIFT = 8,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_sat,
    output logic                 busy
);
    localparam int unsigned PW = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned NP = NUM_STAGE - 1;
    localparam int unsigned RW = ACC_WIDTH + 1;
    // Half-LSB rounding term; collapses to zero when no shift is applied.
    localparam logic [RW-1:0] RND = RW'((RW'(1) << OUT_SHIFT) >> 1);

    logic [A_WIDTH-1:0]          a_q, a_d;
    logic [B_WIDTH-1:0]          b_q, b_d;
    logic signed [PW-1:0]        prod_q [NP];
    logic signed [PW-1:0]        prod_d [NP];
    logic [NUM_STAGE-1:0]        v_q, v_d, first_q, first_d, last_q, last_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        ovf_q, ovf_d;
    logic                        acc_v_q, acc_v_d, acc_last_q, acc_last_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]        dout_q, dout_d;
    logic                        dout_sat_q, dout_sat_d;
    logic                        busy_q, busy_d;

    logic signed [PW-1:0]        a_ext, b_ext;
    logic signed [ACC_WIDTH-1:0] prod_ext, acc_sum;
    logic signed [RW-1:0]        rnd_sum, shifted;
    logic                        fits;
    logic                        emit;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        v_d         = v_q;
        first_d     = first_q;
        last_d      = last_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        acc_v_d     = acc_v_q;
        acc_last_d  = acc_last_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        dout_sat_d  = dout_sat_q;

        a_ext    = {{(PW-A_WIDTH){A_SIGNED & a_q[A_WIDTH-1]}}, a_q};
        b_ext    = {{(PW-B_WIDTH){B_SIGNED & b_q[B_WIDTH-1]}}, b_q};
        prod_ext = ACC_WIDTH'(prod_q[NP-1]);
        acc_sum  = acc_q + prod_ext;
        rnd_sum  = $signed({acc_q[ACC_WIDTH-1], acc_q}) + $signed(RND);
        shifted  = rnd_sum >>> OUT_SHIFT;
        // Result fits when every bit above the output sign bit matches it.
        fits     = (shifted[RW-1:OUT_WIDTH-1] == '0) || (shifted[RW-1:OUT_WIDTH-1] == '1);
        emit     = acc_v_q && acc_last_q;

        if (ce) begin
            a_d     = din0;
            b_d     = din1;
            v_d     = {v_q[NUM_STAGE-2:0], in_valid};
            first_d = {first_q[NUM_STAGE-2:0], in_first};
            last_d  = {last_q[NUM_STAGE-2:0], in_last};
            prod_d[0] = PW'(a_ext * b_ext);
            for (int i = 1; i < int'(NP); i++) begin
                prod_d[i] = prod_q[i-1];
            end

            acc_v_d    = v_q[NUM_STAGE-1];
            acc_last_d = last_q[NUM_STAGE-1];
            if (v_q[NUM_STAGE-1]) begin
                if (first_q[NUM_STAGE-1]) begin
                    acc_d = prod_ext;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = acc_sum;
                    ovf_d = ovf_q | ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                                     (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]));
                end
            end

            out_valid_d = emit;
            if (emit) begin
                dout_sat_d = ovf_q | ~fits;
                if (fits) begin
                    dout_d = shifted[OUT_WIDTH-1:0];
                end else if (shifted[RW-1]) begin
                    dout_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                end else begin
                    dout_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end
        end

        busy_d = (|v_d) | acc_v_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q         <= '0;
            first_q     <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_v_q     <= 1'b0;
            acc_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_sat_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            v_q         <= v_d;
            first_q     <= first_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_v_q     <= acc_v_d;
            acc_last_q  <= acc_last_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            dout_sat_q  <= dout_sat_d;
            busy_q      <= busy_d;
        end
    end

    // Operand and product data carry no reset; their valid tags gate every use.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        prod_q <= prod_d;
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign dout_sat  = dout_sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_hls_mac_pipe.sv
// Scoreboard bench for hls_mac_pipe: arithmetic reference model feeds an expected
// queue, an independent monitor checks every output cycle against it.
module tb_hls_mac_pipe;
    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [13:0] din0 = '0;
    logic [12:0] din1 = '0;
    logic        out_valid;
    logic [15:0] dout;
    logic        dout_sat;
    logic        busy;

    hls_mac_pipe #(
        .A_WIDTH(14), .B_WIDTH(13), .A_SIGNED(1'b1), .B_SIGNED(1'b0),
        .NUM_STAGE(NS), .ACC_WIDTH(32), .OUT_SHIFT(8), .OUT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .out_valid(out_valid), .dout(dout), .dout_sat(dout_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          due;
    } exp_t;

    exp_t   q[$];
    int     stamps[$];
    int     checks = 0;
    int     errors = 0;
    int     ce_cnt = 0;
    bit     ce_edge = 1'b0;
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    logic        prev_ov = 1'b0;
    logic [15:0] prev_d = '0;
    logic        prev_s = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (ce edge %0d)", name, act, exp, ce_cnt);
        end
    endfunction

    // Reference model: exact integer arithmetic on whole groups.
    task automatic model_beat(input logic f, input logic l, input logic [13:0] a,
                              input logic [12:0] b, input int stamp);
        longint prod, sum, wrapped, r;
        bit     clip;
        exp_t   e;
        prod = longint'($signed(a)) * longint'(b);
        if (f) begin
            m_acc = prod;
            m_ovf = 1'b0;
        end else begin
            sum     = m_acc + prod;
            wrapped = longint'(int'(sum));
            if (wrapped != sum) m_ovf = 1'b1;
            m_acc = wrapped;
        end
        if (l) begin
            r    = (m_acc + 128) >>> 8;
            clip = 1'b0;
            if (r > 32767) begin r = 32767; clip = 1'b1; end
            if (r < -32768) begin r = -32768; clip = 1'b1; end
            e.d   = 16'(r);
            e.s   = m_ovf | clip;
            e.due = stamp + NS + 1;
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit c, input bit v, input bit f, input bit l,
                         input logic [13:0] a, input logic [12:0] b);
        @(posedge clk);
        #1;
        ce = c; in_valid = v; in_first = f; in_last = l; din0 = a; din1 = b;
        if (c && v) begin
            stamps.push_back(ce_cnt + 1);
            model_beat(f, l, a, b, ce_cnt + 1);
        end
    endtask

    task automatic idle(input int n, input bit c);
        for (int i = 0; i < n; i++) drive(c, 1'b0, 1'b0, 1'b0, 14'($urandom), 13'($urandom));
    endtask

    // Pin the most recent expectation to a hand-derived constant.
    task automatic expect_last(input logic [15:0] d, input logic s);
        exp_t e;
        e = q.pop_back();
        e.d = d;
        e.s = s;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; ce = 1'b1; in_valid = 1'b0;
        q.delete();
        stamps.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(posedge clk) begin
        ce_edge = ce;
        if (ce) ce_cnt++;
    end

    always @(negedge clk) begin
        bit   exp_v;
        bit   exp_busy;
        exp_t e;
        if (!reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_dout", dout, 0);
            chk("rst_dout_sat", dout_sat, 0);
            chk("rst_busy", busy, 0);
        end else begin
            while (stamps.size() > 0 && stamps[0] < ce_cnt - NS) void'(stamps.pop_front());
            exp_busy = stamps.size() > 0 && stamps[0] <= ce_cnt;
            chk("busy", busy, exp_busy);
            if (!ce_edge) begin
                chk("hold_out_valid", out_valid, prev_ov);
                chk("hold_dout", dout, prev_d);
                chk("hold_dout_sat", dout_sat, prev_s);
            end else begin
                exp_v = q.size() > 0 && q[0].due == ce_cnt;
                chk("out_valid", out_valid, exp_v);
                if (exp_v) begin
                    e = q.pop_front();
                    if (out_valid) begin
                        chk("dout", dout, e.d);
                        chk("dout_sat", dout_sat, e.s);
                    end
                end else begin
                    chk("idle_dout", dout, prev_d);
                    chk("idle_dout_sat", dout_sat, prev_s);
                end
            end
        end
        prev_ov = out_valid;
        prev_d  = dout;
        prev_s  = dout_sat;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [13:0] a;
        idle(3, 1'b1);
        #1 reset = 1'b1;
        idle(2, 1'b1);

        // Single-term group, negative A.
        drive(1, 1, 1, 1, 14'h3FFD, 13'd4096);
        expect_last(16'hFFD0, 1'b0);
        idle(6, 1'b1);

        // Four-beat dot product.
        for (int k = 0; k < 4; k++) drive(1, 1, k == 0, k == 3, 14'd100, 13'd256);
        expect_last(16'd400, 1'b0);
        idle(6, 1'b1);

        // Output clip, then a clean group.
        for (int k = 0; k < 8; k++) drive(1, 1, k == 0, k == 7, 14'd8191, 13'd8191);
        expect_last(16'h7FFF, 1'b1);
        drive(1, 1, 1, 1, 14'd1, 13'd256);
        expect_last(16'd1, 1'b0);
        idle(6, 1'b1);

        // Dot product with a ce=0 gap after beat 2.
        for (int k = 0; k < 3; k++) drive(1, 1, k == 0, 0, 14'd100, 13'd256);
        idle(5, 1'b0);
        drive(1, 1, 0, 1, 14'd100, 13'd256);
        expect_last(16'd400, 1'b0);
        idle(6, 1'b1);

        // ce=0 overlapping a presented result keeps it held.
        drive(1, 1, 1, 1, 14'd5, 13'd256);
        expect_last(16'd5, 1'b0);
        idle(4, 1'b1);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Reset mid-group, then a fresh single-term group.
        drive(1, 1, 1, 0, 14'd77, 13'd999);
        drive(1, 1, 0, 0, 14'd77, 13'd999);
        do_reset();
        drive(1, 1, 1, 1, 14'd1, 13'd256);
        expect_last(16'd1, 1'b0);
        idle(6, 1'b1);

        // Back-to-back single-term groups.
        for (int k = 1; k <= 6; k++) begin
            drive(1, 1, 1, 1, 14'(k), 13'd256);
            expect_last(16'(k), 1'b0);
        end
        idle(10, 1'b1);
        chk("busy_drained", busy, 0);

        // Accumulator wrap sets the sticky overflow flag.
        for (int k = 0; k < 40; k++) drive(1, 1, k == 0, k == 39, 14'h2000, 13'd8191);
        idle(6, 1'b1);

        // Randomised beats, markers and clock enable.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0: a = 14'h1FFF;
                1: a = 14'h2000;
                default: a = 14'($urandom);
            endcase
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  a, 13'($urandom));
        end
        idle(12, 1'b1);
        chk("queue_drained", q.size(), 0);
        chk("busy_final", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
